// File: rtl/fx_ctrl_pkg.sv
// Shared definitions for the effect-parameter scheduler: per-setting FSM states,
// default setting width and counter sizing helper.
package fx_ctrl_pkg;

    typedef enum logic [1:0] {KS_IDLE, KS_DEBOUNCE, KS_RAMP} knob_state_t;

    localparam int SET_WIDTH_DEF = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_ramp_ctrl.sv
// One setting: two-flop synchroniser, packet-strobe debounce and one-LSB-per-step
// ramp of the applied value toward the debounced switch setting.
module param_ramp_ctrl
    import fx_ctrl_pkg::*;
#(
    parameter int               WIDTH         = SET_WIDTH_DEF,
    parameter int               DEBOUNCE_PKTS = 64,
    parameter int               STEP_PKTS     = 441,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             step
);

    localparam int DW = cnt_w(DEBOUNCE_PKTS);
    localparam int SW = cnt_w(STEP_PKTS);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_PKTS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STEP_PKTS - 1);

    // Unsigned one-LSB move toward the target; never overshoots or wraps.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] c,
                                                     input logic [WIDTH-1:0] t);
        if (t > c) return c + WIDTH'(1);
        if (t < c) return c - WIDTH'(1);
        return c;
    endfunction

    logic [WIDTH-1:0] sync_p0, sync_p1;
    logic [WIDTH-1:0] cur, tgt, cand, nxt;
    logic [DW-1:0]    dcnt;
    logic [SW-1:0]    scnt;
    knob_state_t      state;

    assign nxt   = step_toward(cur, tgt);
    assign value = cur;
    assign busy  = (state != KS_IDLE);
    assign step  = (state == KS_RAMP) && (sync_p1 == tgt) && strobe && (scnt == S_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
            state   <= KS_IDLE;
            cur     <= RESET_VAL;
            tgt     <= RESET_VAL;
            cand    <= RESET_VAL;
            dcnt    <= '0;
            scnt    <= '0;
        end else begin
            // sync_p0 -> sync_p1 boundary; everything below decides on sync_p1 only
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            case (state)
                KS_IDLE: begin
                    if (sync_p1 != cur) begin
                        state <= KS_DEBOUNCE;
                        cand  <= sync_p1;
                        dcnt  <= '0;
                    end
                end
                KS_DEBOUNCE: begin
                    if (sync_p1 != cand) begin
                        cand <= sync_p1;
                        dcnt <= '0;
                    end else if (strobe) begin
                        if (dcnt == D_LAST) begin
                            if (cand == cur) begin
                                state <= KS_IDLE;
                            end else begin
                                state <= KS_RAMP;
                                tgt   <= cand;
                                scnt  <= S_LAST;
                            end
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                end
                KS_RAMP: begin
                    // A moved switch pauses the ramp and re-qualifies the new value.
                    if (sync_p1 != tgt) begin
                        state <= KS_DEBOUNCE;
                        cand  <= sync_p1;
                        dcnt  <= '0;
                    end else if (strobe) begin
                        if (scnt == S_LAST) begin
                            cur  <= nxt;
                            scnt <= '0;
                            if (nxt == tgt) state <= KS_IDLE;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fx_param_scheduler.sv
// Applies debounced, click-free ramped LFO frequency and depth-scale settings
// to the DSP block, stepping only on received audio packets.
module fx_param_scheduler
    import fx_ctrl_pkg::*;
#(
    parameter int SET_WIDTH     = SET_WIDTH_DEF,
    parameter int DEBOUNCE_PKTS = 64,
    parameter int STEP_PKTS     = 441,
    parameter int FREQ_RESET    = 0,
    parameter int SCALE_RESET   = 0
) (
    input  logic                 clkI2S,
    input  logic                 rst_n,
    input  logic                 pktI2SRxChanged_i,
    input  logic [SET_WIDTH-1:0] freqSetting_i,
    input  logic [SET_WIDTH-1:0] scaleFactor_i,
    output logic [SET_WIDTH-1:0] freqSetting_o,
    output logic [SET_WIDTH-1:0] scaleFactor_o,
    output logic                 settingsBusy_o,
    output logic                 paramUpdate_o
);

    logic freq_busy, scale_busy, freq_step, scale_step;

    param_ramp_ctrl #(
        .WIDTH        (SET_WIDTH),
        .DEBOUNCE_PKTS(DEBOUNCE_PKTS),
        .STEP_PKTS    (STEP_PKTS),
        .RESET_VAL    (SET_WIDTH'(FREQ_RESET))
    ) u_freq (
        .clk   (clkI2S),
        .rst_n (rst_n),
        .strobe(pktI2SRxChanged_i),
        .raw   (freqSetting_i),
        .value (freqSetting_o),
        .busy  (freq_busy),
        .step  (freq_step)
    );

    param_ramp_ctrl #(
        .WIDTH        (SET_WIDTH),
        .DEBOUNCE_PKTS(DEBOUNCE_PKTS),
        .STEP_PKTS    (STEP_PKTS),
        .RESET_VAL    (SET_WIDTH'(SCALE_RESET))
    ) u_scale (
        .clk   (clkI2S),
        .rst_n (rst_n),
        .strobe(pktI2SRxChanged_i),
        .raw   (scaleFactor_i),
        .value (scaleFactor_o),
        .busy  (scale_busy),
        .step  (scale_step)
    );

    // Both knobs stepping on one strobe still yield a single update pulse.
    always_ff @(posedge clkI2S) begin
        if (!rst_n) begin
            settingsBusy_o <= 1'b0;
            paramUpdate_o  <= 1'b0;
        end else begin
            settingsBusy_o <= freq_busy | scale_busy;
            paramUpdate_o  <= freq_step | scale_step;
        end
    end

endmodule

// File: tb/tb_fx_param_scheduler.sv
// Bench for fx_param_scheduler: directed setting scenarios, an abstract per-setting
// model compared every cycle, and literal checkpoints.
module tb_fx_param_scheduler;

    localparam int W  = 4;
    localparam int DP = 4;
    localparam int SP = 3;
    localparam int FR = 2;
    localparam int SR = 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         strobe = 1'b0;
    logic [W-1:0] fin = '0;
    logic [W-1:0] sin = '0;
    logic [W-1:0] fout, sout;
    logic         busy, upd;

    always #5 clk = ~clk;

    fx_param_scheduler #(
        .SET_WIDTH    (W),
        .DEBOUNCE_PKTS(DP),
        .STEP_PKTS    (SP),
        .FREQ_RESET   (FR),
        .SCALE_RESET  (SR)
    ) dut (
        .clkI2S           (clk),
        .rst_n            (rst_n),
        .pktI2SRxChanged_i(strobe),
        .freqSetting_i    (fin),
        .scaleFactor_i    (sin),
        .freqSetting_o    (fout),
        .scaleFactor_o    (sout),
        .settingsBusy_o   (busy),
        .paramUpdate_o    (upd)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Abstract model: per setting a pending value with a count of stable strobes,
    // and a ramp with a countdown of strobes to the next step.
    int m_cur[2], m_s1[2], m_s[2], m_pval[2], m_tgt[2], m_seen[2], m_wait[2];
    bit m_pend[2], m_ramp[2];
    bit m_busy = 0, m_upd = 0, mv = 0;

    task automatic m_step();
        bit any_busy;
        bit stepped;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_cur[k]  = (k == 0) ? FR : SR;
                m_s1[k]   = m_cur[k];
                m_s[k]    = m_cur[k];
                m_pend[k] = 0;
                m_ramp[k] = 0;
            end
            m_busy = 0;
            m_upd  = 0;
            mv     = 1;
            return;
        end
        any_busy = m_pend[0] | m_ramp[0] | m_pend[1] | m_ramp[1];
        stepped  = 0;
        for (int k = 0; k < 2; k++) begin
            int s;
            s = m_s[k];
            if (m_pend[k]) begin
                if (s != m_pval[k]) begin
                    m_pval[k] = s;
                    m_seen[k] = 0;
                end else if (strobe) begin
                    m_seen[k]++;
                    if (m_seen[k] == DP) begin
                        m_pend[k] = 0;
                        if (m_pval[k] != m_cur[k]) begin
                            m_ramp[k] = 1;
                            m_tgt[k]  = m_pval[k];
                            m_wait[k] = 1;
                        end
                    end
                end
            end else if (m_ramp[k]) begin
                if (s != m_tgt[k]) begin
                    m_ramp[k] = 0;
                    m_pend[k] = 1;
                    m_pval[k] = s;
                    m_seen[k] = 0;
                end else if (strobe) begin
                    m_wait[k]--;
                    if (m_wait[k] == 0) begin
                        m_cur[k] = m_cur[k] + ((m_tgt[k] > m_cur[k]) ? 1 : -1);
                        stepped  = 1;
                        m_wait[k] = SP;
                        if (m_cur[k] == m_tgt[k]) m_ramp[k] = 0;
                    end
                end
            end else if (s != m_cur[k]) begin
                m_pend[k] = 1;
                m_pval[k] = s;
                m_seen[k] = 0;
            end
            m_s[k]  = m_s1[k];
            m_s1[k] = (k == 0) ? int'(fin) : int'(sin);
        end
        m_busy = any_busy;
        m_upd  = stepped;
    endtask

    // Negedge: compare what the last posedge produced, then advance the model
    // with the inputs the next posedge will see.
    initial begin
        forever begin
            @(negedge clk);
            if (mv) begin
                check("cyc_freq",  fout, m_cur[0]);
                check("cyc_scale", sout, m_cur[1]);
                check("cyc_busy",  busy, m_busy);
                check("cyc_upd",   upd,  m_upd);
            end
            if (upd === 1'b1) pulses++;
            m_step();
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            strobe = 1'b1;
            @(posedge clk);
            #2;
            strobe = 1'b0;
            idle(7);
        end
    endtask

    task automatic lit(input string name, input int ef, input int es);
        check({name, "_freq"},  fout, ef);
        check({name, "_scale"}, sout, es);
        check({name, "_mfreq"}, m_cur[0], ef);
        check({name, "_mscale"}, m_cur[1], es);
    endtask

    initial begin
        int p0;
        // Reset, with a strobe held during reset that must be ignored
        rst_n = 1'b0;
        strobe = 1'b1;
        fin = 4'd0;
        sin = 4'd0;
        idle(3);
        strobe = 1'b0;
        rst_n = 1'b1;
        lit("reset", 2, 0);
        check("reset_busy", busy, 0);
        check("reset_upd", upd, 0);

        // Switch at 0 pulls freq down from its reset value 2
        idle(4);
        strobes(8);
        lit("settle0", 0, 0);

        // 0 -> 3 held
        fin = 4'd3;
        idle(4);
        strobes(4);
        lit("up_deb", 0, 0);
        p0 = pulses;
        strobes(1);
        lit("up_s5", 1, 0);
        check("up_busy_mid", busy, 1);
        strobes(3);
        lit("up_s8", 2, 0);
        strobes(3);
        lit("up_s11", 3, 0);
        check("up_pulses", pulses - p0, 3);
        check("up_busy_end", busy, 0);

        // Glitch 3 -> 5 for two strobes, then back
        p0 = pulses;
        fin = 4'd5;
        idle(4);
        strobes(2);
        fin = 4'd3;
        idle(4);
        strobes(4);
        idle(2);
        lit("glitch", 3, 0);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_busy", busy, 0);

        // Back to 0, then 0 -> 6 reversed to 1 at out=3
        fin = 4'd0;
        idle(4);
        strobes(11);
        lit("down0", 0, 0);
        fin = 4'd6;
        idle(4);
        strobes(11);
        lit("rev_at3", 3, 0);
        fin = 4'd1;
        idle(4);
        strobes(4);
        lit("rev_pause", 3, 0);
        strobes(1);
        lit("rev_2", 2, 0);
        strobes(3);
        lit("rev_1", 1, 0);
        idle(2);
        check("rev_busy", busy, 0);

        // Both settings 0 -> 2 together
        fin = 4'd0;
        idle(4);
        strobes(5);
        lit("both_pre", 0, 0);
        fin = 4'd2;
        sin = 4'd2;
        idle(4);
        strobes(4);
        p0 = pulses;
        strobes(1);
        lit("both_1", 1, 1);
        strobes(3);
        lit("both_2", 2, 2);
        check("both_pulses", pulses - p0, 2);

        // Reset mid-ramp at freq=2 (0 -> 4), strobe coincident with reset
        fin = 4'd0;
        idle(4);
        strobes(8);
        lit("pre6", 0, 2);
        fin = 4'd4;
        idle(4);
        strobes(8);
        lit("mid6", 2, 2);
        check("mid6_busy", busy, 1);
        rst_n = 1'b0;
        strobe = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        strobe = 1'b0;
        lit("rst6", 2, 0);
        check("rst6_busy", busy, 0);
        check("rst6_upd", upd, 0);
        idle(4);
        strobes(4);
        lit("redeb", 2, 0);
        strobes(1);
        lit("redeb_s5", 3, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
